vga_warp_timing: RTL and testbench
==================================

VGA_WARP_TIMING -- requirements
Module: vga_warp_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, H_SYNC, H_BP, defaults 16, 96, 48; horizontal front porch, sync and back porch in pixels; HT = H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP, V_SYNC, V_BP, defaults 11, 2, 31; vertical porches and sync in lines; VT = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-005 Parameter SYNC_POL, default 0, asserted level of hsync/vsync.
REQ-006 Parameter NCH, default 3, number of projective accumulator channels (num_x, num_y, denom).
REQ-007 Parameter ACC_W, default 79, two's-complement width of each accumulator and coefficient.
REQ-008 vclock  in  1  pixel clock; the only clock.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 init_in  in  NCH*ACC_W  per-channel frame-start value; channel k at bits [k*ACC_W +: ACC_W].
REQ-011 pix_step_in  in  NCH*ACC_W  per-channel signed per-pixel increment.
REQ-012 row_step_in  in  NCH*ACC_W  per-channel signed line-wrap increment.
REQ-013 coeff_valid  in  1  coefficient set on init_in/pix_step_in/row_step_in is valid.
REQ-014 coeff_ready  out  1  block can accept a coefficient set.
REQ-015 hcount  out  clog2(HT)  pixel index in line; vcount  out  clog2(VT)  line index in frame.
REQ-016 hsync, vsync, blank  out  1 each  sync strobes and blanking.
REQ-017 frame_start  out  1  one-cycle pulse at pixel (0,0).
REQ-018 acc  out  NCH*ACC_W  per-channel accumulator values, same packing as init_in.

Function
REQ-019 All outputs registered; every output is consistent with the hcount/vcount value of the same cycle.
REQ-020 hcount increments each cycle, wraps HT-1 -> 0; vcount increments when hcount wraps, wraps VT-1 -> 0 when hcount==HT-1 and vcount==VT-1 ("frame wrap").
REQ-021 hsync == SYNC_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL; vsync likewise on vcount with V_ parameters, independent of hcount.
REQ-022 blank == 1 iff hcount >= H_ACTIVE or vcount >= V_ACTIVE.
REQ-023 frame_start == 1 iff hcount==0 and vcount==0.
REQ-024 Each channel has active coefficient registers (init, pix, row) and one pending set shared across channels; pending flag full/empty.
REQ-025 coeff_ready == ~pending_full; handshake completes on a cycle with coeff_valid & coeff_ready; that set is written to pending and pending_full sets next cycle.
REQ-026 At frame wrap with pending_full: pending copied to active, pending_full cleared, and acc loaded with the new init, all in the same edge.
REQ-027 At frame wrap without pending_full: acc loaded with existing active init.
REQ-028 Handshake completing on the frame-wrap cycle with pending empty: set goes to pending, applied at the next frame wrap (not the current one).
REQ-029 Non-wrap edges: if hcount==HT-1, acc += row; else acc += pix; arithmetic modulo 2^ACC_W, no saturation.
REQ-030 Consequence: at pixel (h,v) acc == init + h*pix + v*((HT-1)*pix + row) mod 2^ACC_W.
REQ-031 Channels are fully independent; no cross-channel carry.

Reset
REQ-032 reset sampled at posedge vclock, overrides all other activity including a handshake or frame wrap in the same cycle.
REQ-033 Reset values: hcount=0, vcount=0, hsync=vsync=~SYNC_POL, blank=0, frame_start=0, acc=0, active coefficients=0, pending_full=0, coeff_ready=1.
REQ-034 First cycle after reset deassertion counts from (0,0); frame_start is not pulsed for that first frame; first pulse occurs at the first frame wrap.

Verification (bench params H 8/2/2/2 -> HT=14, V 4/1/1/1 -> VT=7, NCH=2, ACC_W=16)
REQ-035 Free-run after reset -> hcount period 14, vcount period 98 cycles; hsync==0 exactly at hcount 10-11; vsync==0 exactly at vcount 5; blank==0 exactly for hcount<8 and vcount<4.
REQ-036 Handshake ch0 init=100 pix=1 row=-13 mid-frame -> coeff_ready drops next cycle; acc0 stays 0 until frame wrap; then acc0=100 at (0,0), 107 at (7,0), 113 at (13,0), 100 at (0,1), coeff_ready returns 1.
REQ-037 Second set (init=-5) offered while pending_full -> not accepted; accepted the cycle after wrap; applied only at the following wrap.
REQ-038 Handshake exactly on frame-wrap cycle with pending empty -> current frame reloads old init; new init appears one frame later.
REQ-039 Overflow: init=0x7FFF pix=1 -> acc wraps to 0x8000 at (1,0).
REQ-040 reset asserted at (5,2) during a handshake -> all outputs at REQ-033 values next cycle, pending discarded, coeff_ready=1.

Source files
------------

// File: rtl/vga_warp_timing.sv
// VGA raster timing generator with per-pixel projective accumulators.
// A new coefficient set is double-buffered and swapped in only at frame wrap.
module vga_warp_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 11,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 31,
    parameter bit SYNC_POL = 1'b0,
    parameter int NCH      = 3,
    parameter int ACC_W    = 79,
    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW = $clog2(HT),
    localparam int VW = $clog2(VT)
) (
    input  logic                 vclock,
    input  logic                 reset,
    input  logic [NCH*ACC_W-1:0] init_in,
    input  logic [NCH*ACC_W-1:0] pix_step_in,
    input  logic [NCH*ACC_W-1:0] row_step_in,
    input  logic                 coeff_valid,
    output logic                 coeff_ready,
    output logic [HW-1:0]        hcount,
    output logic [VW-1:0]        vcount,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 blank,
    output logic                 frame_start,
    output logic [NCH*ACC_W-1:0] acc
);

    localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VT - 1);

    typedef logic signed [ACC_W-1:0] word_t;

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hs_q, vs_q, bl_q, fs_q;
    logic          rdy_q, rdy_d;
    logic          last_col, wrap, take;

    word_t act_init_q [NCH];
    word_t act_pix_q  [NCH];
    word_t act_row_q  [NCH];
    word_t pend_init_q[NCH];
    word_t pend_pix_q [NCH];
    word_t pend_row_q [NCH];
    word_t acc_q      [NCH];
    word_t acc_d      [NCH];

    function automatic logic sync_level(input int pos, input int start, input int len);
        return (pos >= start && pos < start + len) ? SYNC_POL : ~SYNC_POL;
    endfunction

    always_comb begin
        last_col = (h_q == H_LAST);
        wrap     = last_col && (v_q == V_LAST);
        take     = coeff_valid && rdy_q;
        h_d      = last_col ? '0 : h_q + HW'(1);
        v_d      = v_q;
        if (last_col) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
        // ready drops on acceptance; a wrap frees the pending slot
        rdy_d = !take && (rdy_q || wrap);
        for (int k = 0; k < NCH; k++) begin
            if (wrap) begin
                acc_d[k] = rdy_q ? act_init_q[k] : pend_init_q[k];
            end else begin
                acc_d[k] = acc_q[k] + (last_col ? act_row_q[k] : act_pix_q[k]);
            end
        end
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            h_q   <= '0;
            v_q   <= '0;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            bl_q  <= 1'b0;
            fs_q  <= 1'b0;
            rdy_q <= 1'b1;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k]      <= '0;
                act_init_q[k] <= '0;
                act_pix_q[k]  <= '0;
                act_row_q[k]  <= '0;
            end
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            hs_q  <= sync_level(int'(h_d), H_ACTIVE + H_FP, H_SYNC);
            vs_q  <= sync_level(int'(v_d), V_ACTIVE + V_FP, V_SYNC);
            bl_q  <= (int'(h_d) >= H_ACTIVE) || (int'(v_d) >= V_ACTIVE);
            fs_q  <= (h_d == '0) && (v_d == '0);
            rdy_q <= rdy_d;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= acc_d[k];
                if (wrap && !rdy_q) begin
                    act_init_q[k] <= pend_init_q[k];
                    act_pix_q[k]  <= pend_pix_q[k];
                    act_row_q[k]  <= pend_row_q[k];
                end
            end
        end
    end

    // Pending set is pure data; its validity lives in rdy_q.
    always_ff @(posedge vclock) begin
        if (take) begin
            for (int k = 0; k < NCH; k++) begin
                pend_init_q[k] <= init_in[k*ACC_W +: ACC_W];
                pend_pix_q[k]  <= pix_step_in[k*ACC_W +: ACC_W];
                pend_row_q[k]  <= row_step_in[k*ACC_W +: ACC_W];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_acc
        assign acc[g*ACC_W +: ACC_W] = acc_q[g];
    end

    assign hcount      = h_q;
    assign vcount      = v_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign blank       = bl_q;
    assign frame_start = fs_q;
    assign coeff_ready = rdy_q;

endmodule

// File: tb/tb_vga_warp_timing.sv
// Bench for vga_warp_timing: timing vector table, per-cycle scoreboard, coefficient corner cases.
module tb_vga_warp_timing;
    localparam int HT = 14;
    localparam int VT = 7;

    logic        vclock = 1'b0;
    logic        reset;
    logic [31:0] init_in, pix_in, row_in;
    logic        coeff_valid;
    logic        coeff_ready;
    logic [3:0]  hcount;
    logic [2:0]  vcount;
    logic        hsync, vsync, blank, frame_start;
    logic [31:0] acc;

    vga_warp_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .NCH(2), .ACC_W(16)
    ) dut (
        .vclock(vclock), .reset(reset),
        .init_in(init_in), .pix_step_in(pix_in), .row_step_in(row_in),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .frame_start(frame_start),
        .acc(acc)
    );

    always #5 vclock = ~vclock;

    typedef struct {
        logic [3:0]  h;
        logic [2:0]  v;
        logic        hs, vs, bl, fs, rdy;
        logic [31:0] acc;
    } exp_t;

    typedef struct {
        int         n;
        logic [3:0] h;
        logic [2:0] v;
        logic       hs, vs, bl, fs;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[17];
    int          checks = 0;
    int          failures = 0;
    int          n = 0;
    logic [15:0] m_init[2], m_pix[2], m_row[2];
    logic [15:0] p_init[2], p_pix[2], p_row[2];
    logic        m_full = 1'b0;

    function automatic logic [31:0] pk(input int c0, input int c1);
        return {c1[15:0], c0[15:0]};
    endfunction

    function automatic logic [15:0] acc_at(input int ch, input int h, input int v);
        int t;
        t = int'(signed'(m_init[ch])) + h * int'(signed'(m_pix[ch]))
            + v * ((HT - 1) * int'(signed'(m_pix[ch])) + int'(signed'(m_row[ch])));
        return t[15:0];
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int   h, v;
        h     = n % HT;
        v     = (n / HT) % VT;
        e.h   = 4'(h);
        e.v   = 3'(v);
        e.hs  = !(h >= 10 && h < 12);
        e.vs  = !(v == 5);
        e.bl  = !(h < 8 && v < 4);
        e.fs  = (h == 0) && (v == 0) && (n != 0);
        e.rdy = !m_full;
        e.acc = {acc_at(1, h, v), acc_at(0, h, v)};
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s n=%0d got=%h want=%h", name, n, act, want);
        end
    endtask

    task automatic step(input logic rst, input logic vld,
                        input logic [31:0] i, input logic [31:0] p, input logic [31:0] r);
        exp_t e;
        int   h, v;
        logic wrap, take;
        reset       = rst;
        coeff_valid = vld;
        init_in     = i;
        pix_in      = p;
        row_in      = r;
        if (rst) begin
            n = 0;
            m_full = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_init[k] = '0; m_pix[k] = '0; m_row[k] = '0;
            end
        end else begin
            h    = n % HT;
            v    = (n / HT) % VT;
            wrap = (h == HT - 1) && (v == VT - 1);
            take = vld && !m_full;
            if (wrap && m_full) begin
                for (int k = 0; k < 2; k++) begin
                    m_init[k] = p_init[k]; m_pix[k] = p_pix[k]; m_row[k] = p_row[k];
                end
                m_full = 1'b0;
            end
            if (take) begin
                p_init[0] = i[15:0]; p_init[1] = i[31:16];
                p_pix[0]  = p[15:0]; p_pix[1]  = p[31:16];
                p_row[0]  = r[15:0]; p_row[1]  = r[31:16];
                m_full = 1'b1;
            end
            n++;
        end
        sb.push_back(expect_now());
        @(posedge vclock);
        #1;
        e = sb.pop_front();
        chk("timing", {hcount, vcount, hsync, vsync, blank, frame_start},
            {e.h, e.v, e.hs, e.vs, e.bl, e.fs});
        chk("acc", acc, e.acc);
        chk("ready", coeff_ready, e.rdy);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic run_to(input int h, input int v);
        for (int k = 0; k < 2 * HT * VT; k++) begin
            if ((n % HT) == h && ((n / HT) % VT) == v) break;
            idle();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog n=%0d", n);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s1i, s1p, s1r, s2i, s2p, s2r, s3i, s3p, s3r;
        logic        was_full;
        s1i = pk(100, 16'h1234); s1p = pk(1, -2);  s1r = pk(-13, 3);
        s2i = pk(-5, 7);         s2p = pk(2, 3);   s2r = pk(7, -40);
        s3i = pk(16'h7FFF, 16'h8000); s3p = pk(1, -1); s3r = pk(-13, 0);

        tbl[0]  = '{0,   0,  0, 1, 1, 0, 0};
        tbl[1]  = '{7,   7,  0, 1, 1, 0, 0};
        tbl[2]  = '{8,   8,  0, 1, 1, 1, 0};
        tbl[3]  = '{9,   9,  0, 1, 1, 1, 0};
        tbl[4]  = '{10,  10, 0, 0, 1, 1, 0};
        tbl[5]  = '{11,  11, 0, 0, 1, 1, 0};
        tbl[6]  = '{12,  12, 0, 1, 1, 1, 0};
        tbl[7]  = '{13,  13, 0, 1, 1, 1, 0};
        tbl[8]  = '{14,  0,  1, 1, 1, 0, 0};
        tbl[9]  = '{49,  7,  3, 1, 1, 0, 0};
        tbl[10] = '{56,  0,  4, 1, 1, 1, 0};
        tbl[11] = '{70,  0,  5, 1, 0, 1, 0};
        tbl[12] = '{80,  10, 5, 0, 0, 1, 0};
        tbl[13] = '{84,  0,  6, 1, 1, 1, 0};
        tbl[14] = '{97,  13, 6, 1, 1, 1, 0};
        tbl[15] = '{98,  0,  0, 1, 1, 0, 1};
        tbl[16] = '{196, 0,  0, 1, 1, 0, 1};

        repeat (3) step(1'b1, 1'b0, '0, '0, '0);

        for (int t = 0; t < 17; t++) begin
            while (n < tbl[t].n) idle();
            chk($sformatf("tbl%0d", t), {hcount, vcount, hsync, vsync, blank, frame_start},
                {tbl[t].h, tbl[t].v, tbl[t].hs, tbl[t].vs, tbl[t].bl, tbl[t].fs});
        end

        run_to(3, 1);
        step(1'b0, 1'b1, s1i, s1p, s1r);
        chk("ready_drop", coeff_ready, 0);
        chk("acc_hold", acc, 0);

        for (int k = 0; k < 3 * HT * VT; k++) begin
            was_full = m_full;
            step(1'b0, 1'b1, s2i, s2p, s2r);
            if ((n % HT) == 0 && ((n / HT) % VT) == 0) begin
                chk("wrap_acc0", acc[15:0], 100);
                chk("wrap_ready", coeff_ready, 1);
            end
            if (!was_full) break;
        end
        chk("set2_accept_pos", {hcount, vcount}, {4'd1, 3'd0});
        idle();
        run_to(7, 0);
        chk("acc0_7_0", acc[15:0], 107);
        chk("acc1_7_0", acc[31:16], 16'h1226);
        run_to(13, 0);
        chk("acc0_13_0", acc[15:0], 113);
        run_to(0, 1);
        chk("acc0_0_1", acc[15:0], 100);

        run_to(0, 0);
        chk("set2_applied", acc[15:0], 16'hFFFB);

        run_to(13, 6);
        step(1'b0, 1'b1, s3i, s3p, s3r);
        chk("wrap_hs_old_init", acc[15:0], 16'hFFFB);
        chk("wrap_hs_ready", coeff_ready, 0);
        idle();
        run_to(0, 0);
        chk("set3_applied", acc[15:0], 16'h7FFF);
        idle();
        chk("overflow0", acc[15:0], 16'h8000);
        chk("overflow1", acc[31:16], 16'h7FFF);

        run_to(5, 2);
        step(1'b1, 1'b1, s1i, s1p, s1r);
        chk("rst_pos", {hcount, vcount}, 0);
        chk("rst_sync", {hsync, vsync, blank, frame_start}, 4'b1100);
        chk("rst_acc", acc, 0);
        chk("rst_ready", coeff_ready, 1);
        idle();
        run_to(0, 0);
        chk("discard_acc", acc, 0);
        chk("discard_fs", frame_start, 1);
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
